// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter peripheral: register map,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus between the CPU bridge (master) and the timer (slave),
// including the interrupt line back to the CPU.
interface timer_counter_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       Addr;
  logic             WE;
  logic [CNT_W-1:0] DIn;
  logic [CNT_W-1:0] DOut;
  logic             IRQ;

  modport master (output Addr, WE, DIn, input DOut, IRQ);
  modport slave  (input Addr, WE, DIn, output DOut, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes,
// a sticky interrupt flag and a maskable IRQ output.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  tc_state_e        state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic             en_s;
  logic [1:0]       mode_s;
  logic             cnt_gt1_s;
  logic             ctrl_wr_s;
  logic             preset_wr_s;

  assign en_s        = ctrl_q[CTRL_EN];
  assign mode_s      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
  assign cnt_gt1_s   = (count_q > CNT_W'(1));
  assign ctrl_wr_s   = bus.WE && (bus.Addr == TC_CTRL);
  assign preset_wr_s = bus.WE && (bus.Addr == TC_PRESET);

  // State and register file update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_s) state_d = ST_LOAD;
        else      state_d = ST_IDLE;
      end
      ST_LOAD: state_d = ST_CNT;
      ST_CNT: begin
        if (!en_s)          state_d = ST_IDLE;
        else if (cnt_gt1_s) state_d = ST_CNT;
        else                state_d = ST_INT;
      end
      ST_INT: begin
        if (mode_s == MODE_RELOAD) state_d = ST_LOAD;
        else                       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register next values; software CTRL write beats the FSM enable clear,
  // while the FSM flag set beats the software flag clear
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if (ctrl_wr_s || preset_wr_s) irq_flag_d = 1'b0;
    else                          irq_flag_d = irq_flag_q;

    case (state_q)
      ST_LOAD: count_d = preset_q;
      ST_CNT: begin
        if (!en_s) begin
          count_d = count_q;
        end else if (cnt_gt1_s) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
        end
      end
      ST_INT: begin
        if (mode_s == MODE_RELOAD) irq_flag_d = 1'b0;
        else                       ctrl_d[CTRL_EN] = 1'b0;
      end
      default: count_d = count_q;
    endcase

    if (ctrl_wr_s)   ctrl_d   = bus.DIn[3:0];
    else             ctrl_d   = ctrl_d;
    if (preset_wr_s) preset_d = bus.DIn;
    else             preset_d = preset_q;
  end

  // Read mux and masked interrupt output
  always_comb begin
    bus.IRQ = irq_flag_q & ctrl_q[CTRL_IM];
    case (bus.Addr)
      TC_CTRL:   bus.DOut = {{(CNT_W-4){1'b0}}, ctrl_q};
      TC_PRESET: bus.DOut = preset_q;
      TC_COUNT:  bus.DOut = count_q;
      default:   bus.DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter with hand-computed expectations.
module tb_timer_counter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  timer_counter_if #(.CNT_W(32)) bus ();

  timer_counter #(.CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.DIn  = d;
    bus.WE   = 1'b1;
    step(1);
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    chk(tag, bus.DOut, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    // Reset with a write attempted while reset is held
    reset    = 1'b0;
    bus.WE   = 1'b1;
    bus.Addr = 2'd1;
    bus.DIn  = 32'h0000_1234;
    step(2);
    bus.WE = 1'b0;
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count", 2'd2, 32'h0);
    chk("rst_irq", {31'h0, bus.IRQ}, 32'h0);
    reset = 1'b1;
    step(1);

    // One-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    step(2); rd("os_cnt3", 2'd2, 32'd3);
    step(1); rd("os_cnt2", 2'd2, 32'd2);
    step(1); rd("os_cnt1", 2'd2, 32'd1);
    chk("os_irq_lo", {31'h0, bus.IRQ}, 32'h0);
    step(1); rd("os_cnt0", 2'd2, 32'd0);
    chk("os_irq_hi", {31'h0, bus.IRQ}, 32'h1);
    step(1); rd("os_ctrl", 2'd0, 32'h8);
    step(3);
    chk("os_irq_held", {31'h0, bus.IRQ}, 32'h1);
    wr(2'd0, 32'h0);
    chk("os_irq_clr", {31'h0, bus.IRQ}, 32'h0);
    step(2);

    // Auto-reload, PRESET=2: IRQ high after e4, e8, e12
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hFFFF_FF0B);
    rd("ar_ctrl_mask", 2'd0, 32'hB);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      chk($sformatf("ar_irq_e%0d", k), {31'h0, bus.IRQ},
          ((k >= 4) && (k % 4 == 0)) ? 32'h1 : 32'h0);
      if (k == 2 || k == 6 || k == 10) rd($sformatf("ar_cnt_e%0d", k), 2'd2, 32'd2);
    end
    wr(2'd0, 32'h0);
    step(3);

    // Masked interrupt, PRESET=1
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    step(3);
    chk("mask_irq_e3", {31'h0, bus.IRQ}, 32'h0);
    step(2);
    wr(2'd0, 32'h8);
    chk("mask_im_set", {31'h0, bus.IRQ}, 32'h0);
    rd("mask_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h0);

    // Disable mid-count at COUNT=6, then re-enable
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    step(5); rd("dis_cnt7", 2'd2, 32'd7);
    wr(2'd0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      rd($sformatf("dis_hold%0d", k), 2'd2, 32'd6);
    end
    wr(2'd2, 32'h55);
    rd("cnt_ro", 2'd2, 32'd6);
    wr(2'd3, 32'h77);
    rd("rsvd_rd", 2'd3, 32'h0);
    wr(2'd0, 32'h1);
    step(1); rd("reen_e1", 2'd2, 32'd6);
    step(1); rd("reen_e2", 2'd2, 32'd10);
    wr(2'd0, 32'h0);
    step(2);

    // PRESET=0 reaches INT one edge after the load
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    chk("p0_irq_e2", {31'h0, bus.IRQ}, 32'h0);
    step(1);
    chk("p0_irq_e3", {31'h0, bus.IRQ}, 32'h1);
    rd("p0_cnt", 2'd2, 32'd0);
    wr(2'd0, 32'h0);

    // Max PRESET counts down without wrap
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);
    step(2); rd("max_e2", 2'd2, 32'hFFFF_FFFF);
    step(1); rd("max_e3", 2'd2, 32'hFFFF_FFFE);
    wr(2'd0, 32'h0);
    step(2);

    // Flag set beats same-edge PRESET write; CTRL write beats INT enable clear
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step(2); rd("sim_cnt1", 2'd2, 32'd1);
    wr(2'd1, 32'd1);
    chk("sim_set_wins", {31'h0, bus.IRQ}, 32'h1);
    wr(2'd0, 32'hD);
    rd("sim_ctrl_wins", 2'd0, 32'hD);
    chk("sim_irq_clr", {31'h0, bus.IRQ}, 32'h0);
    step(3);
    chk("sim_irq_again", {31'h0, bus.IRQ}, 32'h1);

    // Reset with IRQ high and a write pending
    reset    = 1'b0;
    bus.WE   = 1'b1;
    bus.Addr = 2'd0;
    bus.DIn  = 32'hF;
    step(2);
    bus.WE = 1'b0;
    reset  = 1'b1;
    chk("rst2_irq", {31'h0, bus.IRQ}, 32'h0);
    rd("rst2_ctrl", 2'd0, 32'h0);
    rd("rst2_preset", 2'd1, 32'h0);
    step(3);
    rd("rst2_count", 2'd2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped timer/counter device; a responder on the processor-to-peripheral bridge bus.
- The bridge decodes the device window and forwards the word offset, write strobe and write data.
- The device returns read data combinationally and drives one hardware interrupt line back to the CPU.
- Supports one-shot mode and auto-reload mode.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers and of DIn/DOut.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled at the clk rising edge; reset==0 resets the block.
- Addr  in  2  word offset inside the device window (byte address bits [3:2]).
- WE  in  1  write strobe from the bridge, already qualified by device select and the CPU no-exception condition.
- DIn  in  CNT_W  write data.
- DOut  out  CNT_W  read data, combinational from Addr.
- IRQ  out  1  interrupt request to the CPU hardware interrupt input.

Behaviour:
- Registers:
  - offset 0: CTRL[3:0], read/write. bit0 = Enable, bits2:1 = Mode, bit3 = IM (interrupt mask).
  - offset 1: PRESET, read/write.
  - offset 2: COUNT, read-only.
  - offset 3: reserved, reads 0.
- Reset (reset==0 at an edge): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Consequently IRQ=0 and DOut=CTRL-readback for Addr=0.
- Read:
  - DOut = {zeros, CTRL} for Addr 0, PRESET for 1, COUNT for 2, 0 for 3.
  - Zero latency; reads have no side effects.
- Write (WE=1):
  - Addr 0: CTRL<=DIn[3:0]; DIn upper bits are ignored.
  - Addr 1: PRESET<=DIn.
  - Addr 2 and 3: ignored.
  - Any write to CTRL or PRESET clears irq_flag.
  - Writes take effect at that edge.
- FSM (IDLE, LOAD, CNT, INT):
  - IDLE: if Enable, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - if !Enable, go to IDLE and hold COUNT;
    - else if COUNT>1, COUNT<=COUNT-1;
    - else COUNT<=0, irq_flag<=1, go to INT.
  - INT, Mode 1 (auto-reload): irq_flag<=0; go to LOAD.
  - INT, Mode 0/2/3 (one-shot): CTRL.Enable<=0; go to IDLE; irq_flag is held until a CTRL/PRESET write.
- IRQ = irq_flag & IM. IM=0 masks the output only; the flag is still set and cleared as above.
- Timing for PRESET=N≥1, write of Enable at edge e0:
  - LOAD at e1.
  - COUNT=N after e2.
  - COUNT=1 after e(N+1).
  - INT and irq_flag=1 after e(N+2).
  - Mode 1 period is N+2 cycles, with irq_flag high for 1 cycle.
- PRESET=0: LOAD loads 0, and CNT reaches INT on the next edge (same as N=1).
- Simultaneous events:
  - A software CTRL write in the same cycle as the INT-state Enable clear wins: the written value lands.
  - A software write clearing irq_flag in the same cycle the FSM sets it: the set wins.
- PRESET write during CNT: COUNT is unaffected until the next LOAD.
- Disable mid-count: COUNT freezes. Re-enable restarts from LOAD, reloading PRESET.
- Reset mid-count, or with IRQ high: all state returns to reset values at that edge.
- COUNT never wraps below 0.

Decomposition:
- Shared package holds:
  - register offsets (TC_CTRL=0, TC_PRESET=1, TC_COUNT=2);
  - CTRL bit indices (EN=0, MODE=2:1, IM=3);
  - mode codes (ONESHOT=0, RELOAD=1);
  - FSM state encoding (2 bits).
- Single module, no sub-module: the register file and the FSM are too tightly coupled to split.

Test Plan:
- Reset: hold reset=0 for 2 edges with prior nonzero state → CTRL, PRESET, COUNT read 0 and IRQ=0. Write WE=1 while reset=0 → ignored.
- One-shot: write PRESET=3, then CTRL=0x9 (EN, mode0, IM) at e0 → COUNT reads 3,2,1,0 after e2..e5. IRQ=1 after e5 and stays high; CTRL reads 0x8. A CTRL write of 0 → IRQ=0 next cycle.
- Auto-reload: PRESET=2, CTRL=0xB → IRQ pulses high exactly 1 cycle every 4 cycles for ≥3 periods; COUNT reloads to 2.
- Masking/readback: CTRL=0x1, PRESET=1 → irq_flag sets but IRQ stays 0. Setting IM via a CTRL write clears the flag → IRQ stays 0. Reads at Addr 3 → 0; writes to Addr 2 → COUNT unchanged.
- Disable mid-count: PRESET=10, enable, clear EN when COUNT=6 → COUNT holds 6 for 5 cycles. Re-enable → reload to 10.
- Edge cases:
  - PRESET=0 → INT reached 1 edge after LOAD.
  - PRESET=0xFFFFFFFF: COUNT decrements without wrap.
  - Same-cycle CTRL write at INT → written value retained.
